// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_pkg
// Description : Shared constants and helpers for the fifo block family.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Deepest FIFO read pipeline the read-side engines are built to absorb.
    localparam int RD_LATENCY_MAX = 4;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_stream_buf.sv
`default_nettype none
// ============================================================================
// Module      : rd_stream_buf
// Description : Single-clock first-word-fall-through buffer. The head entry is
//               visible on head_data whenever occ is non-zero; push and pop on
//               the same edge leave occ unchanged and advance the head.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_stream_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [cnt_w(DEPTH+1)-1:0]    occ,
    output logic [DATA_WIDTH-1:0]        head_data
);

    localparam int C_PTR_W = cnt_w(DEPTH);
    localparam int C_OCC_W = cnt_w(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_OCC_W-1:0]    r_occ;
    logic                  w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [C_PTR_W-1:0] ptr_next(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + C_PTR_W'(1);
    endfunction

    // A pop against an empty buffer is ignored rather than corrupting occ.
    assign w_pop     = pop && (r_occ != '0);
    assign occ       = r_occ;
    assign head_data = r_mem[r_rd_ptr];

    // Storage array: data only, no reset needed since occ qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({push, w_pop})
                2'b10:   r_occ <= r_occ + C_OCC_W'(1);
                2'b01:   r_occ <= r_occ - C_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Read-side drain engine for the fifo block. Issues rd_en while
//               the FIFO is non-empty and credit remains, absorbs the fixed
//               FIFO read latency, and re-presents the data as a valid/ready
//               stream with a per-packet out_last marker.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int PKT_LEN    = 4,
    parameter int BUF_DEPTH  = RD_LATENCY + 2
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_rd,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int C_OCC_W  = cnt_w(BUF_DEPTH + 1);
    localparam int C_INF_W  = cnt_w(RD_LATENCY + 1);
    localparam int C_BEAT_W = cnt_w(PKT_LEN);
    localparam int C_SUM_W  = cnt_w(BUF_DEPTH + RD_LATENCY + 1);

    logic [RD_LATENCY-1:0] r_rd_sr;
    logic [C_INF_W-1:0]    r_inflight;
    logic [C_BEAT_W-1:0]   r_beat_cnt;
    logic [C_OCC_W-1:0]    w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic [C_SUM_W-1:0]    w_credit_used;
    logic                  w_push;
    logic                  w_pop;

    // Every buffered or in-flight entry holds one credit; a pop in the
    // current cycle only frees its credit from the next cycle onward, so the
    // buffer can never be overrun even when all in-flight reads land at once.
    assign w_credit_used = C_SUM_W'(w_occ) + C_SUM_W'(r_inflight);
    assign rd_en         = !rst && !fifo_empty && (w_credit_used < C_SUM_W'(BUF_DEPTH));

    // The read issued RD_LATENCY edges ago has its data on data_rd now.
    assign w_push = r_rd_sr[RD_LATENCY-1];

    assign out_valid = (w_occ != '0);
    assign w_pop     = out_valid && out_ready;
    assign out_data  = out_valid ? w_head : '0;
    assign out_last  = out_valid && (r_beat_cnt == C_BEAT_W'(PKT_LEN - 1));

    generate
        if (RD_LATENCY == 1) begin : g_sr_single
            // Single-stage read pipeline: the flag is the issued read itself.
            always_ff @(posedge rd_clk or posedge rst) begin
                if (rst) begin
                    r_rd_sr <= '0;
                end else begin
                    r_rd_sr <= rd_en;
                end
            end
        end else begin : g_sr_multi
            // Multi-stage read pipeline tracking each issued read.
            always_ff @(posedge rd_clk or posedge rst) begin
                if (rst) begin
                    r_rd_sr <= '0;
                end else begin
                    r_rd_sr <= {r_rd_sr[RD_LATENCY-2:0], rd_en};
                end
            end
        end
    endgenerate

    // Count of reads issued but not yet landed in the buffer.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({rd_en, w_push})
                2'b10:   r_inflight <= r_inflight + C_INF_W'(1);
                2'b01:   r_inflight <= r_inflight - C_INF_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Beat position within the current packet, advanced on each accepted beat.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            if (r_beat_cnt == C_BEAT_W'(PKT_LEN - 1)) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + C_BEAT_W'(1);
            end
        end
    end

    rd_stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (data_rd),
        .pop       (w_pop),
        .occ       (w_occ),
        .head_data (w_head)
    );

endmodule
`default_nettype wire
